// File: rtl/tx_phyretrain.sv
// ---------------------------------------------------------------------------
// tx_phyretrain
//
// Initiator side of the PHYRETRAIN sideband handshake. When the LTSM enables
// the block it latches a local retrain encoding from the pending causes,
// sends PHYRETRAIN_START_REQ through the shared sideband wrapper (yielding to
// the RX responder and to a busy wrapper), then waits for the partner's
// PHYRETRAIN_START_RESP and reports completion or timeout.
//
// Ports:
//   i_clk                 block clock
//   i_rst                 asynchronous active-high reset
//   i_phyretrain_en       LTSM enable; low returns the block to IDLE
//   i_speedidle_req       local cause: speed degrade needed
//   i_repair_req          local cause: lane repair needed
//   i_SB_Busy             sideband wrapper is transmitting
//   i_falling_edge_busy   one-cycle pulse: wrapper consumed the message
//   i_rx_valid            RX responder valid; TX must not raise valid then
//   i_rx_msg_valid        decoded partner message present this cycle
//   i_decoded_SB_msg      decoded partner message code
//   o_encoded_SB_msg_tx   message code toward the sideband encoder
//   o_retrain_encoding_tx local encoding (001 TXSELFCAL, 010 SPEEDIDLE,
//                         100 REPAIR), also consumed by the RX responder
//   o_valid_tx            TX message valid toward the wrapper
//   o_phyretrain_end_tx   handshake complete
//   o_timeout             handshake timed out
// ---------------------------------------------------------------------------
module tx_phyretrain #(
    parameter int SB_MSG_WIDTH   = 4,
    parameter int TIMEOUT_CYCLES = 800000,
    parameter int CNT_WIDTH      = 20
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_phyretrain_en,
    input  logic                    i_speedidle_req,
    input  logic                    i_repair_req,
    input  logic                    i_SB_Busy,
    input  logic                    i_falling_edge_busy,
    input  logic                    i_rx_valid,
    input  logic                    i_rx_msg_valid,
    input  logic [SB_MSG_WIDTH-1:0] i_decoded_SB_msg,
    output logic [SB_MSG_WIDTH-1:0] o_encoded_SB_msg_tx,
    output logic [2:0]              o_retrain_encoding_tx,
    output logic                    o_valid_tx,
    output logic                    o_phyretrain_end_tx,
    output logic                    o_timeout
);

    localparam logic [SB_MSG_WIDTH-1:0] MSG_NONE       = SB_MSG_WIDTH'(0);
    localparam logic [SB_MSG_WIDTH-1:0] MSG_START_REQ  = SB_MSG_WIDTH'(1);
    localparam logic [SB_MSG_WIDTH-1:0] MSG_START_RESP = SB_MSG_WIDTH'(2);

    localparam logic [2:0] ENC_TXSELFCAL = 3'b001;
    localparam logic [2:0] ENC_SPEEDIDLE = 3'b010;
    localparam logic [2:0] ENC_REPAIR    = 3'b100;

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = CNT_WIDTH'(0);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    typedef enum logic [2:0] {
        ST_IDLE          = 3'd0,
        ST_SEND_REQ      = 3'd1,
        ST_WAIT_RESP     = 3'd2,
        ST_TEST_FINISHED = 3'd3,
        ST_TIMEOUT       = 3'd4
    } state_t;

    // Speed degrade outranks lane repair; with no cause the retrain is a
    // plain self-calibration.
    function automatic logic [2:0] select_encoding(input logic speedidle,
                                                   input logic repair);
        logic [2:0] enc;
        if (speedidle) begin
            enc = ENC_SPEEDIDLE;
        end else if (repair) begin
            enc = ENC_REPAIR;
        end else begin
            enc = ENC_TXSELFCAL;
        end
        return enc;
    endfunction

    state_t                    state_q, state_d;
    logic [2:0]                enc_q, enc_d;
    logic [SB_MSG_WIDTH-1:0]   msg_q, msg_d;
    logic                      pending_q, pending_d;
    logic                      resp_seen_q, resp_seen_d;
    logic                      valid_q, valid_d;
    logic                      valid_prev_q, valid_prev_d;
    logic [CNT_WIDTH-1:0]      cnt_q, cnt_d;
    logic                      end_q, end_d;
    logic                      timeout_q, timeout_d;

    logic                      resp_s;
    logic                      valid_fall_s;
    logic                      expired_s;

    assign resp_s       = i_rx_msg_valid && (i_decoded_SB_msg == MSG_START_RESP);
    // The wrapper dropped our valid last cycle: the request has gone out.
    assign valid_fall_s = valid_prev_q && !valid_q;
    assign expired_s    = (cnt_q == CNT_LAST);

    // Next-state logic; a low enable overrides every other transition.
    always_comb begin
        state_d = state_q;
        if (!i_phyretrain_en) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_SEND_REQ;
                end
                ST_SEND_REQ: begin
                    // resp_seen covers a RESP that beat the valid falling edge.
                    if (valid_fall_s) begin
                        if (resp_seen_q || resp_s) begin
                            state_d = ST_TEST_FINISHED;
                        end else begin
                            state_d = ST_WAIT_RESP;
                        end
                    end else if (expired_s) begin
                        state_d = ST_TIMEOUT;
                    end else begin
                        state_d = ST_SEND_REQ;
                    end
                end
                ST_WAIT_RESP: begin
                    if (resp_s || resp_seen_q) begin
                        state_d = ST_TEST_FINISHED;
                    end else if (expired_s) begin
                        state_d = ST_TIMEOUT;
                    end else begin
                        state_d = ST_WAIT_RESP;
                    end
                end
                ST_TEST_FINISHED: begin
                    state_d = ST_TEST_FINISHED;
                end
                ST_TIMEOUT: begin
                    state_d = ST_TIMEOUT;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Request launch: valid/pending arbitration against the RX responder and
    // the wrapper, plus the message code and encoding latched on entry.
    always_comb begin
        valid_d      = valid_q;
        pending_d    = pending_q;
        valid_prev_d = valid_q;
        enc_d        = enc_q;
        msg_d        = msg_q;

        if (i_falling_edge_busy || (state_d == ST_IDLE) || (state_d == ST_TIMEOUT)) begin
            valid_d = 1'b0;
        end else if (pending_q && !i_SB_Busy && !i_rx_valid) begin
            valid_d   = 1'b1;
            pending_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end

        // A blocked request stays pending; only leaving to IDLE drops it.
        if (state_d == ST_IDLE) begin
            pending_d = 1'b0;
        end else if (state_q == ST_IDLE) begin
            pending_d = 1'b1;
        end else begin
            pending_d = pending_d;
        end

        if (state_q == ST_IDLE) begin
            if (state_d == ST_SEND_REQ) begin
                msg_d = MSG_START_REQ;
                enc_d = select_encoding(i_speedidle_req, i_repair_req);
            end else begin
                msg_d = MSG_NONE;
                enc_d = enc_q;
            end
        end else begin
            msg_d = msg_q;
            enc_d = enc_q;
        end
    end

    // Handshake bookkeeping: timeout counter, early-RESP flag, status flags.
    always_comb begin
        cnt_d       = cnt_q;
        resp_seen_d = resp_seen_q;
        end_d       = end_q;
        timeout_d   = timeout_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d       = CNT_ZERO;
                resp_seen_d = 1'b0;
                end_d       = 1'b0;
                timeout_d   = 1'b0;
            end
            ST_SEND_REQ, ST_WAIT_RESP: begin
                cnt_d       = cnt_q + CNT_ONE;
                resp_seen_d = resp_seen_q || resp_s;
            end
            ST_TEST_FINISHED: begin
                end_d = 1'b1;
            end
            ST_TIMEOUT: begin
                timeout_d = 1'b1;
            end
            default: begin
                cnt_d = cnt_q;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= ST_IDLE;
            enc_q        <= 3'b000;
            msg_q        <= MSG_NONE;
            pending_q    <= 1'b0;
            resp_seen_q  <= 1'b0;
            valid_q      <= 1'b0;
            valid_prev_q <= 1'b0;
            cnt_q        <= CNT_ZERO;
            end_q        <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            enc_q        <= enc_d;
            msg_q        <= msg_d;
            pending_q    <= pending_d;
            resp_seen_q  <= resp_seen_d;
            valid_q      <= valid_d;
            valid_prev_q <= valid_prev_d;
            cnt_q        <= cnt_d;
            end_q        <= end_d;
            timeout_q    <= timeout_d;
        end
    end

    assign o_encoded_SB_msg_tx   = msg_q;
    assign o_retrain_encoding_tx = enc_q;
    assign o_valid_tx            = valid_q;
    assign o_phyretrain_end_tx   = end_q;
    assign o_timeout             = timeout_q;

endmodule

// File: tb/tb_tx_phyretrain.sv
// ---------------------------------------------------------------------------
// tb_tx_phyretrain
//
// Randomized scenarios against an event-time reference: for each handshake
// the bench computes, from the blocking windows, busy pulse and RESP timing,
// the cycle at which each output must rise and fall, and compares every
// output on every cycle.
// ---------------------------------------------------------------------------
module tb_tx_phyretrain;

    localparam int SBW = 4;
    localparam int TO  = 20;
    localparam int INF = 1 << 20;

    logic           clk = 1'b0;
    logic           rst;
    logic           en, sp_req, rp_req, sb_busy, fe_busy, rx_valid, rx_msg_valid;
    logic [SBW-1:0] dec_msg;
    logic [SBW-1:0] enc_msg;
    logic [2:0]     retrain_enc;
    logic           valid_tx, end_tx, tmo;

    int             n_checks = 0;
    int             n_fail   = 0;
    int             scn_id   = 0;
    logic [2:0]     prev_enc = 3'b000;

    tx_phyretrain #(
        .SB_MSG_WIDTH  (SBW),
        .TIMEOUT_CYCLES(TO),
        .CNT_WIDTH     (20)
    ) dut (
        .i_clk                (clk),
        .i_rst                (rst),
        .i_phyretrain_en      (en),
        .i_speedidle_req      (sp_req),
        .i_repair_req         (rp_req),
        .i_SB_Busy            (sb_busy),
        .i_falling_edge_busy  (fe_busy),
        .i_rx_valid           (rx_valid),
        .i_rx_msg_valid       (rx_msg_valid),
        .i_decoded_SB_msg     (dec_msg),
        .o_encoded_SB_msg_tx  (enc_msg),
        .o_retrain_encoding_tx(retrain_enc),
        .o_valid_tx           (valid_tx),
        .o_phyretrain_end_tx  (end_tx),
        .o_timeout            (tmo)
    );

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, act, exp);
        end
    endtask

    // mode: 0 RESP after valid drops, 1 RESP while request in flight,
    //       2 no RESP (timeout), 3 enable dropped while valid is high.
    task automatic run_scn(input int mode, input int a, input int b, input int d,
                           input int e, input bit sp, input bit rp);
        int         r, p, q, k, end_at, to_at, last;
        logic [2:0] exp_enc;
        logic       mv;
        logic [3:0] dv;
        scn_id++;
        exp_enc = sp ? 3'b010 : (rp ? 3'b100 : 3'b001);
        // Pending is registered at cycle 1; valid rises the cycle after the
        // first cycle (>=1) in which neither rx_valid nor busy is high.
        r = (a + b + 1 > 2) ? a + b + 1 : 2;
        p = (mode == 3) ? INF : r + d;
        q = INF; end_at = INF; to_at = INF;
        case (mode)
            0: begin
                q = p + 2 + e;
                end_at = q + 2;
                k = end_at + 1 + int'($urandom_range(0, 2));
            end
            1: begin
                q = r + (e % (p + 2 - r));
                end_at = p + 3;
                k = end_at + 1 + int'($urandom_range(0, 2));
            end
            2: begin
                // SEND_REQ entered at cycle 1; flag one cycle after TIMEOUT.
                to_at = 1 + TO + 1;
                k = to_at + 1 + int'($urandom_range(0, 2));
            end
            default: begin
                k = r + int'($urandom_range(0, 3));
            end
        endcase
        last = k + 2 + int'($urandom_range(0, 2));

        for (int c = 0; c <= last; c++) begin
            chk_eq($sformatf("s%0d valid@%0d", scn_id, c), 32'(valid_tx),
                   32'(c >= r && c <= p && c <= k));
            chk_eq($sformatf("s%0d msg@%0d", scn_id, c), 32'(enc_msg),
                   (c >= 1 && c <= k + 1) ? 32'd1 : 32'd0);
            chk_eq($sformatf("s%0d enc@%0d", scn_id, c), 32'(retrain_enc),
                   (c >= 1) ? 32'(exp_enc) : 32'(prev_enc));
            chk_eq($sformatf("s%0d end@%0d", scn_id, c), 32'(end_tx),
                   32'(c >= end_at && c <= k + 1));
            chk_eq($sformatf("s%0d timeout@%0d", scn_id, c), 32'(tmo),
                   32'(c >= to_at && c <= k + 1));

            en = (c < k);
            if (c == 0) begin
                sp_req = sp;
                rp_req = rp;
            end else begin
                sp_req = 1'($urandom_range(0, 1));
                rp_req = 1'($urandom_range(0, 1));
            end
            rx_valid = (c < a) ? 1'b1 : ((c < r) ? 1'b0 : 1'($urandom_range(0, 1)));
            sb_busy  = (c >= a && c < a + b) ? 1'b1 :
                       ((c < r) ? 1'b0 : 1'($urandom_range(0, 1)));
            fe_busy  = (c == p) || (c > k + 1 && $urandom_range(0, 3) == 0);
            mv = 1'($urandom_range(0, 1));
            dv = 4'($urandom_range(0, 15));
            if (mv && dv == 4'd2) dv = 4'd7;
            if (c == q) begin
                mv = 1'b1;
                dv = 4'd2;
            end else if (c > k + 1 && $urandom_range(0, 3) == 0) begin
                mv = 1'b1;   // RESP while idle must be ignored
                dv = 4'd2;
            end
            rx_msg_valid = mv;
            dec_msg      = dv;
            @(posedge clk);
            #1;
        end
        prev_enc = exp_enc;
    endtask

    task automatic chk_all_zero(input string tag);
        chk_eq({tag, " valid"},   32'(valid_tx),    32'd0);
        chk_eq({tag, " msg"},     32'(enc_msg),     32'd0);
        chk_eq({tag, " enc"},     32'(retrain_enc), 32'd0);
        chk_eq({tag, " end"},     32'(end_tx),      32'd0);
        chk_eq({tag, " timeout"}, 32'(tmo),         32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; en = 1'b0; sp_req = 1'b0; rp_req = 1'b0; sb_busy = 1'b0;
        fe_busy = 1'b0; rx_valid = 1'b0; rx_msg_valid = 1'b0; dec_msg = '0;
        #2;
        chk_all_zero("reset");
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;

        // Directed: normal, early RESP, arbitration, priority x2, timeout, abort.
        run_scn(0, 0, 0, 2, 3, 1'b0, 1'b0);
        run_scn(1, 0, 0, 3, 1, 1'b0, 1'b0);
        run_scn(0, 6, 2, 2, 1, 1'b0, 1'b0);
        run_scn(0, 1, 1, 1, 2, 1'b1, 1'b1);
        run_scn(1, 2, 0, 2, 3, 1'b0, 1'b1);
        run_scn(2, 1, 1, 2, 0, 1'b0, 1'b1);
        run_scn(3, 0, 1, 0, 0, 1'b1, 1'b0);

        for (int i = 0; i < 30; i++) begin
            run_scn(int'($urandom_range(0, 3)), int'($urandom_range(0, 5)),
                    int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)));
        end

        // Asynchronous reset in the middle of a handshake.
        en = 1'b1; sp_req = 1'b1; rp_req = 1'b0; sb_busy = 1'b0; rx_valid = 1'b0;
        fe_busy = 1'b0; rx_msg_valid = 1'b0;
        for (int i = 0; i < 10 && !valid_tx; i++) begin
            @(posedge clk); #1;
        end
        chk_eq("rst_mid valid_before", 32'(valid_tx), 32'd1);
        chk_eq("rst_mid msg_before", 32'(enc_msg), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero("rst_mid");
        @(posedge clk); #1;
        en = 1'b0;
        rst = 1'b0;
        prev_enc = 3'b000;
        run_scn(0, 0, 0, 2, 3, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tx_phyretrain.md
# tx_phyretrain

Initiator side of the PHYRETRAIN sideband handshake inside the LTSM. When the LTSM enables PHYRETRAIN, the block:
- picks the local retrain encoding from the pending retrain causes;
- sends PHYRETRAIN_START_REQ through the sideband wrapper, sharing the wrapper with the RX responder;
- waits for the partner's PHYRETRAIN_START_RESP and reports completion or timeout to the LTSM.

The local encoding also feeds the RX responder, which uses it for state resolution.

## Interface
Parameters:
- SB_MSG_WIDTH, 4, width of encoded/decoded sideband message codes
- TIMEOUT_CYCLES, 800000, handshake timeout in i_clk cycles (8 ms at 100 MHz)
- CNT_WIDTH, 20, timeout counter width; must satisfy 2^CNT_WIDTH > TIMEOUT_CYCLES

Ports:
- i_clk  in  1  single clock for the block
- i_rst  in  1  reset, asynchronous and active-high
- i_phyretrain_en  in  1  LTSM enable; low returns the block to IDLE
- i_speedidle_req  in  1  local cause: speed degrade needed
- i_repair_req  in  1  local cause: lane repair needed
- i_SB_Busy  in  1  sideband is transmitting
- i_falling_edge_busy  in  1  one-cycle pulse: sideband consumed the current message
- i_rx_valid  in  1  RX responder's valid; TX must not raise valid while it is high
- i_rx_msg_valid  in  1  a decoded partner message is present this cycle
- i_decoded_SB_msg  in  SB_MSG_WIDTH  decoded partner message code
- o_encoded_SB_msg_tx  out  SB_MSG_WIDTH  message code for the sideband encoder
- o_retrain_encoding_tx  out  3  local encoding: 001 TXSELFCAL, 010 SPEEDIDLE, 100 REPAIR
- o_valid_tx  out  1  TX message valid toward the wrapper
- o_phyretrain_end_tx  out  1  handshake complete
- o_timeout  out  1  handshake timed out

## Operation
- Message codes:
  - PHYRETRAIN_START_REQ = 1
  - PHYRETRAIN_START_RESP = 2
- Encoding selection, sampled on the IDLE->SEND_REQ transition:
  - SPEEDIDLE (010) if i_speedidle_req;
  - else REPAIR (100) if i_repair_req;
  - else TXSELFCAL (001).
  - Held until the next entry; not cleared in IDLE.
- States: IDLE, SEND_REQ, WAIT_RESP, TEST_FINISHED, TIMEOUT.
  - IDLE -> SEND_REQ when i_phyretrain_en. On this transition: o_encoded_SB_msg_tx<=1, encoding latched, pending flag set.
  - SEND_REQ -> TEST_FINISHED on the falling edge of o_valid_tx if resp_seen is set, or if a RESP arrives that same cycle.
  - SEND_REQ -> WAIT_RESP on the falling edge of o_valid_tx otherwise.
  - WAIT_RESP -> TEST_FINISHED when i_rx_msg_valid && i_decoded_SB_msg==2, or when resp_seen is set.
  - SEND_REQ/WAIT_RESP -> TIMEOUT when the timeout counter reaches TIMEOUT_CYCLES-1.
  - TEST_FINISHED and TIMEOUT hold until i_phyretrain_en falls.
  - Any state -> IDLE when !i_phyretrain_en; this has priority over all other transitions.
- Falling edge of o_valid_tx: registered copy of o_valid_tx is 1 and current o_valid_tx is 0.
- resp_seen: set in SEND_REQ or WAIT_RESP when i_rx_msg_valid && decoded==2. Cleared in IDLE. This covers a partner RESP that arrives before the wrapper drops valid.
- Valid logic, in priority order:
  1. i_falling_edge_busy, entering IDLE, or entering TIMEOUT: o_valid_tx<=0.
  2. Pending && !i_SB_Busy && !i_rx_valid: o_valid_tx<=1 and pending cleared.
  - Pending persists while blocked, so a busy wrapper or an active RX message only delays the request; it is never lost.
- Timeout counter:
  - Cleared in IDLE.
  - Increments each cycle in SEND_REQ and WAIT_RESP.
  - Frozen in TEST_FINISHED and TIMEOUT.
- IDLE outputs: o_encoded_SB_msg_tx<=0, o_phyretrain_end_tx<=0, o_timeout<=0.
- Decoded messages other than 2 are ignored.

## Timing
- Reset values: all outputs 0, CS=IDLE, pending=0, resp_seen=0, counter=0.
- Enable at cycle N: CS=SEND_REQ and o_encoded_SB_msg_tx=1 at N+1. o_valid_tx=1 at N+2 at the earliest (pending registered at N+1, valid at N+2) if !i_SB_Busy && !i_rx_valid.
- o_valid_tx stays high until i_falling_edge_busy. It is 0 the cycle after the pulse; the state leaves SEND_REQ one cycle after that.
- RESP in WAIT_RESP at cycle M: CS=TEST_FINISHED at M+1; o_phyretrain_end_tx=1 at M+2, registered on the transition.
- Timeout: o_timeout=1 one cycle after CS enters TIMEOUT, exactly TIMEOUT_CYCLES cycles after SEND_REQ entry plus one.
- Enable drop at cycle K: CS=IDLE and o_valid_tx=0 at K+1; other outputs clear at K+2.
- i_rst asserted mid-handshake: all outputs 0 immediately, with no clock needed.

## Test plan
- Normal handshake:
  - Stimulus: en=1 with no causes; falling_edge_busy pulse 3 cycles after valid rises; RESP 5 cycles later.
  - Required: encoding=001, msg=1, valid high 3 cycles, end=1, o_timeout=0.
- Early response:
  - Stimulus: RESP arrives while o_valid_tx=1, before falling_edge_busy.
  - Required: state goes directly to TEST_FINISHED after the valid falling edge; end=1; WAIT_RESP never visited.
- Arbitration:
  - Stimulus: i_rx_valid=1 for 6 cycles at enable, then i_SB_Busy=1 for 2 more cycles.
  - Required: o_valid_tx stays 0 throughout, then rises the cycle after both are low.
- Priority:
  - Stimulus: i_repair_req=1 with i_speedidle_req=1, then i_repair_req=1 alone, across two enables.
  - Required: encoding 010 for the first enable, then 100 for the second.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=20, no RESP sent.
  - Required: o_timeout=1 at cycle 21 after SEND_REQ entry, o_valid_tx=0, end=0; dropping en clears o_timeout.
- Abort:
  - Stimulus: en dropped while valid=1, then i_rst pulsed mid-handshake.
  - Required: for the en drop, IDLE and valid=0 next cycle; for the reset, all outputs 0 asynchronously.
